mole_round_ctrl: RTL and testbench

Game-round controller for the whack-a-mole design, directly upstream of the high-score display stage. It runs one game:
- lights one of four mole LEDs per round from an LFSR;
- detects button hits within a timed window;
- counts hits as a saturating single decimal digit.

It presents the score both as binary and as an active-low seven-segment pattern (bit order gfedcba). That pattern is the score bus the high-score stage compares against its stored best, and the score holds stable after the game ends.

---
 rtl/mole_pkg.sv | 25 ++
 rtl/seg7_decode.sv | 14 +
 rtl/mole_round_ctrl.sv | 124 ++++++++++++
 tb/tb_mole_round_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole datapath: FSM states,
// active-low seven-segment patterns and the round LFSR.
package mole_pkg;

  typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

  // Active-low, bit order gfedcba.
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // x^8+x^6+x^5+x^4+1 as taps on bits 7,5,4,3 of a left-shifting register.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Binary digit to active-low gfedcba pattern; anything above 9 shows a dash.
module seg7_decode
  import mole_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (value < 4'd10) seg = SEG_DIGIT[value];
  end

endmodule

// File: rtl/mole_round_ctrl.sv
// One game of whack-a-mole: LFSR-picked mole per round, timed hit window,
// saturating decimal score shown in binary and on a seven-segment bus.
module mole_round_ctrl
  import mole_pkg::*;
#(
  parameter int         MOLE_TICKS = 50_000_000,
  parameter int         GAP_TICKS  = 12_500_000,
  parameter int         ROUNDS     = 20,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] mole_led,
  output logic [3:0] score_bin,
  output logic [6:0] score_seg,
  output logic       busy,
  output logic       game_over
);

  localparam int WIN_W = $clog2(MOLE_TICKS);
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int RND_W = $clog2(ROUNDS + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(MOLE_TICKS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
  localparam logic [RND_W-1:0] RND_END  = RND_W'(ROUNDS);

  state_t           state, state_nxt;
  logic [7:0]       lfsr, lfsr_nxt;
  logic [3:0]       btn_q;
  logic [3:0]       mole, mole_nxt;
  logic [3:0]       score, score_nxt;
  logic [WIN_W-1:0] win_cnt, win_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic [RND_W-1:0] rnd_cnt, rnd_nxt;

  logic [3:0] press;
  logic       miss, hit;

  assign press = btn & ~btn_q;
  // A stray press disqualifies the round even if the lit button also went down.
  assign miss  = |(press & ~mole);
  assign hit   = |(press & mole) & ~miss;

  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    mole_nxt  = mole;
    score_nxt = score;
    win_nxt   = win_cnt;
    gap_nxt   = gap_cnt;
    rnd_nxt   = rnd_cnt;
    case (state)
      IDLE, DONE: begin
        if (state == IDLE || start) lfsr_nxt = lfsr_step(lfsr);
        if (start) begin
          state_nxt = SHOW;
          score_nxt = '0;
          rnd_nxt   = '0;
          win_nxt   = '0;
          mole_nxt  = onehot4(lfsr_nxt[1:0]);
        end
      end
      SHOW: begin
        win_nxt = win_cnt + 1'b1;
        if (miss || hit || win_cnt == WIN_LAST) begin
          state_nxt = GAP;
          gap_nxt   = '0;
        end
        if (hit) score_nxt = (score >= 4'd9) ? 4'd9 : score + 4'd1;
      end
      GAP: begin
        gap_nxt = gap_cnt + 1'b1;
        if (gap_cnt == GAP_LAST) begin
          rnd_nxt = rnd_cnt + 1'b1;
          if (rnd_nxt == RND_END) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SHOW;
            lfsr_nxt  = lfsr_step(lfsr);
            win_nxt   = '0;
            mole_nxt  = onehot4(lfsr_nxt[1:0]);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      lfsr    <= LFSR_SEED;
      btn_q   <= '0;
      mole    <= '0;
      score   <= '0;
      win_cnt <= '0;
      gap_cnt <= '0;
      rnd_cnt <= '0;
    end else begin
      state   <= state_nxt;
      lfsr    <= lfsr_nxt;
      btn_q   <= btn;
      mole    <= mole_nxt;
      score   <= score_nxt;
      win_cnt <= win_nxt;
      gap_cnt <= gap_nxt;
      rnd_cnt <= rnd_nxt;
    end
  end

  assign mole_led  = (state == SHOW) ? mole : 4'b0000;
  assign score_bin = score;
  assign busy      = (state == SHOW) || (state == GAP);
  assign game_over = (state == DONE);

  seg7_decode u_seg (
    .value (score),
    .seg   (score_seg)
  );

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed bench: instance a (3 rounds) covers timing, instance b (12 rounds)
// covers scoring, misses, saturation, restart and mid-game reset.
module tb_mole_round_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [3:0] btn_a = 4'b0, btn_b = 4'b0;
  logic [3:0] mole_a, mole_b, score_a, score_b;
  logic [6:0] seg_a, seg_b;
  logic       busy_a, busy_b, over_a, over_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mole_round_ctrl #(.MOLE_TICKS(8), .GAP_TICKS(4), .ROUNDS(3), .LFSR_SEED(8'hA5)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .btn(btn_a),
    .mole_led(mole_a), .score_bin(score_a), .score_seg(seg_a),
    .busy(busy_a), .game_over(over_a)
  );

  mole_round_ctrl #(.MOLE_TICKS(8), .GAP_TICKS(4), .ROUNDS(12), .LFSR_SEED(8'hA5)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .btn(btn_b),
    .mole_led(mole_b), .score_bin(score_b), .score_seg(seg_b),
    .busy(busy_b), .game_over(over_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_b_lit();
    int n = 0;
    while (mole_b == 4'b0 && n < 50) begin
      tick();
      n++;
    end
    check("wait_lit_b", 32'(mole_b != 4'b0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int total;
    tick();
    check("rst_led", mole_a, 4'b0);
    check("rst_seg", seg_a, 7'b1000000);
    reset = 1'b0;
    repeat (100) tick();
    check("idle_led", mole_a, 4'b0);
    check("idle_seg", seg_a, 7'b1000000);
    check("idle_score", score_a, 0);
    check("idle_busy", busy_a, 0);
    check("idle_over", over_a, 0);

    // No presses on a: 8 lit, 4 dark, game over after 3 x 12 cycles.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("a_busy", busy_a, 1);
    check("a_onehot", 32'($onehot(mole_a)), 1);
    cnt = 0;
    while (mole_a != 4'b0 && cnt < 50) begin cnt++; tick(); end
    check("a_lit_cycles", cnt, 8);
    total = cnt;
    cnt = 0;
    while (mole_a == 4'b0 && !over_a && cnt < 50) begin cnt++; tick(); end
    check("a_dark_cycles", cnt, 4);
    total += cnt;
    while (!over_a && total < 100) begin tick(); total++; end
    check("a_over_cycles", total, 36);
    check("a_over_score", score_a, 0);
    check("a_over_busy", busy_a, 0);
    repeat (5) tick();
    check("a_over_hold", over_a, 1);

    // Hit at window cycle 3.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (3) tick();
    btn_b = mole_b;
    tick();
    check("b_hit_score", score_b, 1);
    check("b_hit_seg", seg_b, 7'b1111001);
    check("b_hit_led", mole_b, 4'b0);
    btn_b = 4'b0;
    cnt = 0;
    while (mole_b == 4'b0 && cnt < 50) begin cnt++; tick(); end
    check("b_gap_cycles", cnt, 4);

    // Lit and unlit pressed together counts as a miss.
    btn_b = 4'b1111;
    tick();
    btn_b = 4'b0;
    check("b_miss_score", score_b, 1);
    check("b_miss_led", mole_b, 4'b0);
    check("b_miss_busy", busy_b, 1);

    // Hit the remaining ten moles; score saturates at 9.
    for (int i = 1; i <= 10; i++) begin
      wait_b_lit();
      btn_b = mole_b;
      tick();
      btn_b = 4'b0;
      check("b_run_score", score_b, (1 + i > 9) ? 9 : 1 + i);
    end
    cnt = 0;
    while (!over_b && cnt < 20) begin cnt++; tick(); end
    check("b_over", over_b, 1);
    check("b_sat_score", score_b, 9);
    check("b_sat_seg", seg_b, 7'b0010000);
    check("b_over_busy", busy_b, 0);
    repeat (3) tick();
    check("b_score_hold", score_b, 9);

    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_restart_score", score_b, 0);
    check("b_restart_seg", seg_b, 7'b1000000);
    check("b_restart_busy", busy_b, 1);
    check("b_restart_over", over_b, 0);

    // Reach score 2, then reset during SHOW.
    btn_b = mole_b;
    tick();
    btn_b = 4'b0;
    wait_b_lit();
    btn_b = mole_b;
    tick();
    btn_b = 4'b0;
    wait_b_lit();
    check("b_pre_rst_score", score_b, 2);
    reset = 1'b1;
    #1;
    check("b_rst_led", mole_b, 4'b0);
    check("b_rst_score", score_b, 0);
    check("b_rst_busy", busy_b, 0);
    tick();
    reset = 1'b0;
    tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_post_busy", busy_b, 1);
    check("b_post_onehot", 32'($onehot(mole_b)), 1);
    btn_b = mole_b;
    tick();
    btn_b = 4'b0;
    check("b_post_score", score_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
